// File: rtl/upsampler_h_sequencer_if.sv
// ---------------------------------------------------------------------------
// upsampler_h_sequencer_if
//   Pixel-in / window-out bundle for the horizontal 2x upsampler sequencer.
//   Signal names follow the sequencer's own point of view (_i = into the
//   sequencer, _o = out of it).
//
//   pix_i        : input pixel, raster order (FP_WIDTH bits)
//   valid_i      : pix_i valid
//   ready_o      : sequencer accepts pix_i this cycle
//   window_o     : 1x5 window, index 4 = newest sample
//   col_o        : upsampled column of the window centre (index 2)
//   row_o        : row of the window
//   valid_o      : single-cycle qualifier for window_o/col_o/row_o
//   frame_done_o : pulses with the last window of a frame
//
//   slave  : the sequencer side
//   master : the pixel source / window consumer side
// ---------------------------------------------------------------------------
interface upsampler_h_sequencer_if #(
    parameter int EXP_WIDTH  = 5,
    parameter int FRAC_WIDTH = 10
);
    localparam int FP_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;

    logic [FP_WIDTH-1:0]      pix_i;
    logic                     valid_i;
    logic                     ready_o;
    logic [4:0][FP_WIDTH-1:0] window_o;
    logic [15:0]              col_o;
    logic [15:0]              row_o;
    logic                     valid_o;
    logic                     frame_done_o;

    modport slave (
        input  pix_i,
        input  valid_i,
        output ready_o,
        output window_o,
        output col_o,
        output row_o,
        output valid_o,
        output frame_done_o
    );

    modport master (
        output pix_i,
        output valid_i,
        input  ready_o,
        input  window_o,
        input  col_o,
        input  row_o,
        input  valid_o,
        input  frame_done_o
    );
endinterface

// File: rtl/upsampler_h_sequencer.sv
// ---------------------------------------------------------------------------
// upsampler_h_sequencer
//   Turns a raster stream of pixels into the zero-stuffed 2x horizontal
//   stream p0,0,p1,0,...,p(W-1),0,0,0 per row and presents a sliding 1x5
//   window over it for a downstream 5-tap horizontal convolution. Each row
//   starts with an all-zero window history (left zero padding) and ends with
//   two pad zeros (right padding), giving exactly 2*W windows per row.
//   Pixel data is passed through untouched.
//
//   Ports:
//     clk_i : sole clock, rising edge
//     rst_i : asynchronous active-low reset
//     bus   : upsampler_h_sequencer_if.slave
//             (pix_i/valid_i/ready_o in, window_o/col_o/row_o/valid_o/
//              frame_done_o out)
// ---------------------------------------------------------------------------
module upsampler_h_sequencer #(
    parameter int EXP_WIDTH  = 5,
    parameter int FRAC_WIDTH = 10,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    upsampler_h_sequencer_if.slave  bus
);
    localparam int FP_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;

    localparam logic [15:0] PIX_PER_ROW = 16'(IMG_WIDTH);
    // Stream index of the second pad zero: the last sample of a row.
    localparam logic [15:0] LAST_K      = 16'(2 * IMG_WIDTH + 1);
    localparam logic [15:0] LAST_ROW    = 16'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_EVEN,   // waiting for a real pixel
        S_ODD,    // stuffing the zero after a pixel
        S_FLUSH   // two right-padding zeros at row end
    } state_e;

    state_e state_q, state_d;
    logic   flush_q, flush_d;   // 0 = first pad cycle, 1 = second

    // Window history, index 4 = newest
    logic [4:0][FP_WIDTH-1:0] sr_q;
    logic [15:0]              pix_cnt_q;  // pixels accepted in this row
    logic [15:0]              k_q;        // stream index of next sample
    logic [15:0]              row_q;

    // Registered outputs
    logic [4:0][FP_WIDTH-1:0] win_q;
    logic [15:0]              col_q;
    logic [15:0]              row_out_q;
    logic                     valid_q;
    logic                     fd_q;

    // FSM outputs
    logic                     ready;
    logic                     shift_en;
    logic [FP_WIDTH-1:0]      shift_val;

    logic [4:0][FP_WIDTH-1:0] sr_shifted;
    logic                     row_end;
    logic                     emit;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_EVEN;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // pix_cnt_q already counts the pixel shifted in EVEN when ODD is entered,
    // so reaching PIX_PER_ROW in ODD means the row's last pixel is in.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        unique case (state_q)
            S_EVEN: begin
                if (bus.valid_i) state_d = S_ODD;
            end
            S_ODD: begin
                if (pix_cnt_q < PIX_PER_ROW) state_d = S_EVEN;
                else                         state_d = S_FLUSH;
            end
            S_FLUSH: begin
                flush_d = ~flush_q;
                if (flush_q) state_d = S_EVEN;
            end
            default: state_d = S_EVEN;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (ready depends on state only, never on valid_i)
    // -----------------------------------------------------------------------
    always_comb begin
        ready     = 1'b0;
        shift_en  = 1'b0;
        shift_val = '0;
        unique case (state_q)
            S_EVEN: begin
                ready     = 1'b1;
                shift_en  = bus.valid_i;
                shift_val = bus.pix_i;
            end
            S_ODD: begin
                shift_en = 1'b1;
            end
            S_FLUSH: begin
                shift_en = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    always_comb begin
        sr_shifted = {shift_val, sr_q[4:1]};
        row_end    = (state_q == S_FLUSH) && flush_q;
        // Windows are only emitted once the centre tap holds stream index 0.
        emit       = shift_en && (k_q >= 16'd2);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sr_q      <= '0;
            pix_cnt_q <= '0;
            k_q       <= '0;
            row_q     <= '0;
        end else if (shift_en) begin
            if (row_end) begin
                // The second pad sample is still captured into the output
                // register this cycle; the history itself restarts clean.
                sr_q      <= '0;
                pix_cnt_q <= '0;
                k_q       <= '0;
                row_q     <= (row_q == LAST_ROW) ? '0 : row_q + 16'd1;
            end else begin
                sr_q <= sr_shifted;
                k_q  <= k_q + 16'd1;
                if (state_q == S_EVEN) pix_cnt_q <= pix_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            win_q     <= '0;
            col_q     <= '0;
            row_out_q <= '0;
            valid_q   <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            valid_q <= emit;
            fd_q    <= emit && (k_q == LAST_K) && (row_q == LAST_ROW);
            if (emit) begin
                win_q     <= sr_shifted;
                col_q     <= k_q - 16'd2;
                row_out_q <= row_q;
            end
        end
    end

    assign bus.ready_o      = ready;
    assign bus.window_o     = win_q;
    assign bus.col_o        = col_q;
    assign bus.row_o        = row_out_q;
    assign bus.valid_o      = valid_q;
    assign bus.frame_done_o = fd_q;

endmodule

// File: tb/tb_upsampler_h_sequencer.sv
// ---------------------------------------------------------------------------
// tb_upsampler_h_sequencer
//   Directed bench for upsampler_h_sequencer at W=4, H=2, FP16.
// ---------------------------------------------------------------------------
module tb_upsampler_h_sequencer;
    localparam int W = 4;
    localparam int H = 2;

    logic clk   = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    upsampler_h_sequencer_if #(.EXP_WIDTH(5), .FRAC_WIDTH(10)) bus ();

    upsampler_h_sequencer #(
        .EXP_WIDTH (5),
        .FRAC_WIDTH(10),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .bus  (bus)
    );

    typedef struct {
        logic [15:0]       col;
        logic [15:0]       row;
        logic [4:0][15:0]  win;
        logic              fd;
    } obs_t;

    obs_t obs_q[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) begin
            obs_t o;
            o.col = bus.col_o;
            o.row = bus.row_o;
            o.win = bus.window_o;
            o.fd  = bus.frame_done_o;
            obs_q.push_back(o);
        end
    end

    // Expected window from the zero-stuffed stream definition:
    // u[2i] = pixel i (i < W), every other u = 0, window[j] = u[col+2-4+j].
    function automatic logic [4:0][15:0] exp_win(input logic [15:0] p0, p1, p2, p3,
                                                 input int col);
        logic [15:0]      px [4];
        logic [4:0][15:0] w;
        px = '{p0, p1, p2, p3};
        w  = '0;
        for (int j = 0; j < 5; j++) begin
            int s;
            s = col - 2 + j;
            if (s >= 0 && (s % 2) == 0 && (s / 2) < W) w[j] = px[s / 2];
        end
        return w;
    endfunction

    // Present p and wait (bounded) until it is taken; returns on the negedge
    // after the accepting rising edge, with valid_i still high.
    task automatic push(input logic [15:0] p);
        bit taken;
        taken       = 1'b0;
        bus.pix_i   = p;
        bus.valid_i = 1'b1;
        for (int n = 0; n < 20 && !taken; n++) begin
            if (bus.ready_o === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                taken = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!taken) begin
            errors++;
            $display("FAIL push_timeout: pixel %h not taken, ready_o=%b required 1", p, bus.ready_o);
        end
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", bus.ready_o); end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", bus.valid_o); end
        checks++; if (bus.frame_done_o !== 1'b0) begin errors++; $display("FAIL rst_fd: got %b required 0", bus.frame_done_o); end
        checks++; if (bus.col_o !== 16'd0) begin errors++; $display("FAIL rst_col: got %0d required 0", bus.col_o); end
        checks++; if (bus.row_o !== 16'd0) begin errors++; $display("FAIL rst_row: got %0d required 0", bus.row_o); end
        checks++; if (bus.window_o !== 80'd0) begin errors++; $display("FAIL rst_win: got %h required 0", bus.window_o); end
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_row();
        obs_q.delete();
        push(16'h3C00); push(16'h4000); push(16'h4200); push(16'h4400);
        idle(5);
        checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL basic_count: got %0d required 8", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 8; i++) begin
            checks++; if (obs_q[i].col !== 16'(i)) begin errors++; $display("FAIL basic_col[%0d]: got %0d required %0d", i, obs_q[i].col, i); end
            checks++; if (obs_q[i].row !== 16'd0) begin errors++; $display("FAIL basic_row[%0d]: got %0d required 0", i, obs_q[i].row); end
            checks++; if (obs_q[i].win !== exp_win(16'h3C00, 16'h4000, 16'h4200, 16'h4400, i)) begin
                errors++; $display("FAIL basic_win[%0d]: got %h required %h", i, obs_q[i].win, exp_win(16'h3C00, 16'h4000, 16'h4200, 16'h4400, i)); end
            checks++; if (obs_q[i].fd !== 1'b0) begin errors++; $display("FAIL basic_fd[%0d]: got %b required 0", i, obs_q[i].fd); end
        end
        if (obs_q.size() >= 8) begin
            checks++; if (obs_q[0].win !== {16'h4000, 16'h0000, 16'h3C00, 16'h0000, 16'h0000}) begin
                errors++; $display("FAIL basic_col0_win: got %h required 4000_0000_3c00_0000_0000", obs_q[0].win); end
            checks++; if (obs_q[7].win !== {16'h0000, 16'h0000, 16'h0000, 16'h4400, 16'h0000}) begin
                errors++; $display("FAIL basic_col7_win: got %h required 0000_0000_0000_4400_0000", obs_q[7].win); end
        end
        // Outputs hold the last window while idle
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b required 0", bus.valid_o); end
        checks++; if (bus.col_o !== 16'd7) begin errors++; $display("FAIL hold_col: got %0d required 7", bus.col_o); end
        checks++; if (bus.window_o !== {16'h0000, 16'h0000, 16'h0000, 16'h4400, 16'h0000}) begin
            errors++; $display("FAIL hold_win: got %h required 0000_0000_0000_4400_0000", bus.window_o); end
    endtask

    task automatic test_stall();
        logic [15:0] px [4];
        px = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        obs_q.delete();
        for (int p = 0; p < 4; p++) begin
            push(px[p]);
            if (p < 3) begin
                bus.valid_i = 1'b0;
                @(negedge clk);               // zero-stuff shift lands here
                for (int s = 0; s < 2; s++) begin
                    @(negedge clk);
                    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL stall_ready[%0d.%0d]: got %b required 1", p, s, bus.ready_o); end
                    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d.%0d]: got %b required 0", p, s, bus.valid_o); end
                end
            end
        end
        idle(5);
        checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL stall_count: got %0d required 8", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 8; i++) begin
            checks++; if (obs_q[i].col !== 16'(i)) begin errors++; $display("FAIL stall_col[%0d]: got %0d required %0d", i, obs_q[i].col, i); end
            checks++; if (obs_q[i].row !== 16'd1) begin errors++; $display("FAIL stall_row[%0d]: got %0d required 1", i, obs_q[i].row); end
            checks++; if (obs_q[i].win !== exp_win(16'h3C00, 16'h4000, 16'h4200, 16'h4400, i)) begin
                errors++; $display("FAIL stall_win[%0d]: got %h required %h", i, obs_q[i].win, exp_win(16'h3C00, 16'h4000, 16'h4200, 16'h4400, i)); end
            checks++; if (obs_q[i].fd !== (i == 7)) begin errors++; $display("FAIL stall_fd[%0d]: got %b required %b", i, obs_q[i].fd, (i == 7)); end
        end
    endtask

    task automatic test_back_to_back();
        obs_q.delete();
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        push(16'h5555); push(16'h6666); push(16'h7777); push(16'h8888);
        idle(5);
        checks++; if (obs_q.size() != 16) begin errors++; $display("FAIL b2b_count: got %0d required 16", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 16; i++) begin
            int c;
            logic [4:0][15:0] e;
            c = i % 8;
            e = (i < 8) ? exp_win(16'h1111, 16'h2222, 16'h3333, 16'h4444, c)
                        : exp_win(16'h5555, 16'h6666, 16'h7777, 16'h8888, c);
            checks++; if (obs_q[i].col !== 16'(c)) begin errors++; $display("FAIL b2b_col[%0d]: got %0d required %0d", i, obs_q[i].col, c); end
            checks++; if (obs_q[i].row !== 16'(i / 8)) begin errors++; $display("FAIL b2b_row[%0d]: got %0d required %0d", i, obs_q[i].row, i / 8); end
            checks++; if (obs_q[i].win !== e) begin errors++; $display("FAIL b2b_win[%0d]: got %h required %h", i, obs_q[i].win, e); end
            checks++; if (obs_q[i].fd !== (i == 15)) begin errors++; $display("FAIL b2b_fd[%0d]: got %b required %b", i, obs_q[i].fd, (i == 15)); end
        end
        if (obs_q.size() >= 9) begin
            checks++; if (obs_q[8].win !== {16'h6666, 16'h0000, 16'h5555, 16'h0000, 16'h0000}) begin
                errors++; $display("FAIL b2b_row1_col0: got %h required 6666_0000_5555_0000_0000", obs_q[8].win); end
        end
    endtask

    task automatic test_ready();
        obs_q.delete();
        push(16'h3C00);
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL ready_odd0: got %b required 0", bus.ready_o); end
        push(16'h4000);
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL ready_odd1: got %b required 0", bus.ready_o); end
        push(16'h4200);
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL ready_odd2: got %b required 0", bus.ready_o); end
        push(16'h4400);
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL ready_odd3: got %b required 0", bus.ready_o); end
        // Offer a junk pixel throughout the pad cycles; it must not be taken
        bus.pix_i   = 16'hDEAD;
        bus.valid_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL ready_flush0: got %b required 0", bus.ready_o); end
        @(negedge clk);
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL ready_flush1: got %b required 0", bus.ready_o); end
        @(negedge clk);
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL ready_even: got %b required 1", bus.ready_o); end
        idle(3);
        checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL ready_count: got %0d required 8", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 8; i++) begin
            checks++; if (obs_q[i].row !== 16'd0) begin errors++; $display("FAIL ready_row[%0d]: got %0d required 0", i, obs_q[i].row); end
            checks++; if (obs_q[i].win !== exp_win(16'h3C00, 16'h4000, 16'h4200, 16'h4400, i)) begin
                errors++; $display("FAIL ready_win[%0d]: got %h required %h", i, obs_q[i].win, exp_win(16'h3C00, 16'h4000, 16'h4200, 16'h4400, i)); end
        end
    endtask

    task automatic test_reset_mid_row();
        push(16'h3C00);
        push(16'h4000);
        bus.valid_i = 1'b0;
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b required 1", bus.valid_o); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b required 0", bus.valid_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b required 1", bus.ready_o); end
        checks++; if (bus.col_o !== 16'd0) begin errors++; $display("FAIL mid_rst_col: got %0d required 0", bus.col_o); end
        checks++; if (bus.row_o !== 16'd0) begin errors++; $display("FAIL mid_rst_row: got %0d required 0", bus.row_o); end
        checks++; if (bus.window_o !== 80'd0) begin errors++; $display("FAIL mid_rst_win: got %h required 0", bus.window_o); end
        checks++; if (bus.frame_done_o !== 1'b0) begin errors++; $display("FAIL mid_rst_fd: got %b required 0", bus.frame_done_o); end
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        obs_q.delete();
        push(16'h0123); push(16'h0456); push(16'h0789); push(16'h0ABC);
        idle(5);
        checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL mid_count: got %0d required 8", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 8; i++) begin
            checks++; if (obs_q[i].col !== 16'(i)) begin errors++; $display("FAIL mid_col[%0d]: got %0d required %0d", i, obs_q[i].col, i); end
            checks++; if (obs_q[i].row !== 16'd0) begin errors++; $display("FAIL mid_row[%0d]: got %0d required 0", i, obs_q[i].row); end
            checks++; if (obs_q[i].win !== exp_win(16'h0123, 16'h0456, 16'h0789, 16'h0ABC, i)) begin
                errors++; $display("FAIL mid_win[%0d]: got %h required %h", i, obs_q[i].win, exp_win(16'h0123, 16'h0456, 16'h0789, 16'h0ABC, i)); end
        end
        if (obs_q.size() >= 1) begin
            checks++; if (obs_q[0].win !== {16'h0456, 16'h0000, 16'h0123, 16'h0000, 16'h0000}) begin
                errors++; $display("FAIL mid_col0_win: got %h required 0456_0000_0123_0000_0000", obs_q[0].win); end
        end
    endtask

    initial begin
        bus.pix_i   = '0;
        bus.valid_i = 1'b0;
        test_reset();
        test_basic_row();       // row 0
        test_stall();           // row 1, frame end
        test_back_to_back();    // rows 0 and 1
        test_ready();           // row 0 after wrap
        test_reset_mid_row();   // aborts row 1
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
